// File: rtl/arbiter_env_ctrl_pkg.sv
// Shared encodings and defaults for the arbiter environment controller
// and its four-phase client sub-blocks.
package arbiter_env_ctrl_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_HOLD = 2'd2,
    C_REL  = 2'd3
  } client_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_UP   = 2'd1,
    R_GNT  = 2'd2,
    R_DN   = 2'd3
  } root_state_t;

endpackage

// File: rtl/arbiter_env_ctrl_hs4_client.sv
// Four-phase handshake client: requests, holds the grant for a programmable
// number of cycles, releases, and waits for the grant to drop.
module hs4_client
  import arbiter_env_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_ok,
  input  logic [3:0]       hold_cycles,
  input  logic             g_s,
  output logic             r,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             idle_grant,
  output logic             busy
);

  client_state_t    state, state_next;
  logic [3:0]       hold_cnt, hold_cnt_next;
  logic [CNT_W-1:0] grant_cnt_next;
  logic             g_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= C_IDLE;
      hold_cnt  <= 4'd0;
      grant_cnt <= '0;
      r         <= 1'b0;
      g_prev    <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      grant_cnt <= grant_cnt_next;
      r         <= (state_next == C_REQ) || (state_next == C_HOLD);
      g_prev    <= g_s;
    end
  end

  // start_ok is only looked at in IDLE, so dropping it never aborts a handshake
  always_comb begin
    state_next     = state;
    hold_cnt_next  = hold_cnt;
    grant_cnt_next = grant_cnt;
    case (state)
      C_IDLE: begin
        if (start_ok && !g_s) state_next = C_REQ;
      end
      C_REQ: begin
        if (g_s) begin
          state_next    = C_HOLD;
          hold_cnt_next = hold_cycles;
          if (grant_cnt != {CNT_W{1'b1}})
            grant_cnt_next = grant_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      C_HOLD: begin
        if (hold_cnt == 4'd0) state_next = C_REL;
        else                  hold_cnt_next = hold_cnt - 4'd1;
      end
      C_REL: begin
        if (!g_s) state_next = C_IDLE;
      end
      default: state_next = C_IDLE;
    endcase
  end

  assign idle_grant = g_s && !g_prev && (state == C_IDLE);
  assign busy       = (state != C_IDLE);

endmodule

// File: rtl/arbiter_env_ctrl.sv
// Environment around a two-input asynchronous arbiter cell: two four-phase
// clients, a root responder with programmable delay, and error monitors.
module arbiter_env_ctrl
  import arbiter_env_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic [1:0]       req_mask,
  input  logic [3:0]       hold_cycles,
  input  logic [3:0]       gc_delay,
  input  logic             g0_a,
  input  logic             g1_a,
  input  logic             rc_a,
  output logic             r0,
  output logic             r1,
  output logic             gc,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic             mutex_err,
  output logic             proto_err,
  output logic             busy
);

  logic [SYNC_STAGES-1:0] g0_sync, g1_sync, rc_sync;
  logic                   g0_s, g1_s, rc_s;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      g0_sync <= '0;
      g1_sync <= '0;
      rc_sync <= '0;
    end else begin
      g0_sync <= {g0_sync[SYNC_STAGES-2:0], g0_a};
      g1_sync <= {g1_sync[SYNC_STAGES-2:0], g1_a};
      rc_sync <= {rc_sync[SYNC_STAGES-2:0], rc_a};
    end
  end

  assign g0_s = g0_sync[SYNC_STAGES-1];
  assign g1_s = g1_sync[SYNC_STAGES-1];
  assign rc_s = rc_sync[SYNC_STAGES-1];

  logic c0_idle_grant, c1_idle_grant, c0_busy, c1_busy;

  hs4_client #(.CNT_W(CNT_W)) u_client0 (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .start_ok    (en && req_mask[0]),
    .hold_cycles (hold_cycles),
    .g_s         (g0_s),
    .r           (r0),
    .grant_cnt   (grant_cnt0),
    .idle_grant  (c0_idle_grant),
    .busy        (c0_busy)
  );

  hs4_client #(.CNT_W(CNT_W)) u_client1 (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .start_ok    (en && req_mask[1]),
    .hold_cycles (hold_cycles),
    .g_s         (g1_s),
    .r           (r1),
    .grant_cnt   (grant_cnt1),
    .idle_grant  (c1_idle_grant),
    .busy        (c1_busy)
  );

  root_state_t root_state, root_next;
  logic [3:0]  root_cnt, root_cnt_next;
  logic        root_proto;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      root_state <= R_IDLE;
      root_cnt   <= 4'd0;
      gc         <= 1'b0;
      mutex_err  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      root_state <= root_next;
      root_cnt   <= root_cnt_next;
      gc         <= (root_next == R_GNT) || (root_next == R_DN);
      mutex_err  <= mutex_err || (g0_s && g1_s);
      proto_err  <= proto_err || root_proto || c0_idle_grant || c1_idle_grant;
    end
  end

  // A request withdrawn during R_UP is flagged but the grant cycle still runs out
  always_comb begin
    root_next     = root_state;
    root_cnt_next = root_cnt;
    root_proto    = 1'b0;
    case (root_state)
      R_IDLE: begin
        if (rc_s) begin
          root_next     = R_UP;
          root_cnt_next = gc_delay;
        end
      end
      R_UP: begin
        if (!rc_s) root_proto = 1'b1;
        if (root_cnt == 4'd0) root_next = R_GNT;
        else                  root_cnt_next = root_cnt - 4'd1;
      end
      R_GNT: begin
        if (!rc_s) begin
          root_next     = R_DN;
          root_cnt_next = gc_delay;
        end
      end
      R_DN: begin
        if (root_cnt == 4'd0) root_next = R_IDLE;
        else                  root_cnt_next = root_cnt - 4'd1;
      end
      default: root_next = R_IDLE;
    endcase
  end

  assign busy = c0_busy || c1_busy || (root_state != R_IDLE);

endmodule

// File: tb/tb_arbiter_env_ctrl.sv
// Scoreboard bench for arbiter_env_ctrl with a behavioural arbiter-cell model;
// a second instance with 2-bit counters covers saturation.
module tb_arbiter_env_ctrl;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] req_mask = 2'b00;
  logic [3:0] hold_cycles = 4'd0;
  logic [3:0] gc_delay = 4'd0;
  logic       g0_a, g1_a, rc_a;
  logic       r0, r1, gc, mutex_err, proto_err, busy;
  logic [7:0] grant_cnt0, grant_cnt1;
  logic       s_r0, s_r1, s_gc, s_mutex, s_proto, s_busy;
  logic [1:0] s_cnt0, s_cnt1;

  logic model_on = 1'b0;
  logic man_g0 = 1'b0, man_g1 = 1'b0, man_rc = 1'b0;
  logic mg0, mg1, mrc;
  logic parent_ok, gc_prev, last_win;
  int   grants0, grants1;

  int tests_run = 0;
  int tests_failed = 0;

  typedef enum {S_R0, S_R1, S_GC, S_CNT0, S_CNT1, S_MUTEX, S_PROTO, S_BUSY, S_SAT1} sel_t;
  typedef struct {
    string name;
    sel_t  sel;
    int    value;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign g0_a = model_on ? mg0 : man_g0;
  assign g1_a = model_on ? mg1 : man_g1;
  assign rc_a = model_on ? mrc : man_rc;

  arbiter_env_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .req_mask(req_mask),
    .hold_cycles(hold_cycles), .gc_delay(gc_delay),
    .g0_a(g0_a), .g1_a(g1_a), .rc_a(rc_a),
    .r0(r0), .r1(r1), .gc(gc), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .mutex_err(mutex_err), .proto_err(proto_err), .busy(busy)
  );

  arbiter_env_ctrl #(.SYNC_STAGES(SYNC), .CNT_W(2)) dut_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .en(en), .req_mask(req_mask),
    .hold_cycles(hold_cycles), .gc_delay(gc_delay),
    .g0_a(g0_a), .g1_a(g1_a), .rc_a(rc_a),
    .r0(s_r0), .r1(s_r1), .gc(s_gc), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1),
    .mutex_err(s_mutex), .proto_err(s_proto), .busy(s_busy)
  );

  // Arbiter cell model: one grant at a time, only inside a fresh parent grant,
  // alternating when both clients are waiting; grants are counted here.
  always @(negedge clk) begin
    if (rst) begin
      mg0 = 1'b0; mg1 = 1'b0; mrc = 1'b0;
      parent_ok = 1'b0; gc_prev = 1'b0; last_win = 1'b1;
      grants0 = 0; grants1 = 0;
    end else if (model_on) begin
      if (mg0 && !r0) mg0 = 1'b0;
      if (mg1 && !r1) mg1 = 1'b0;
      if (gc && !gc_prev && mrc) parent_ok = 1'b1;
      if (gc && parent_ok && !mg0 && !mg1) begin
        if (r0 && (!r1 || last_win)) begin
          mg0 = 1'b1; last_win = 1'b0; grants0++;
        end else if (r1) begin
          mg1 = 1'b1; last_win = 1'b1; grants1++;
        end
      end
      mrc = r0 || r1 || mg0 || mg1;
      if (!mrc) parent_ok = 1'b0;
      gc_prev = gc;
    end
  end

  function automatic int read_sel(input sel_t sel);
    case (sel)
      S_R0:    return int'(r0);
      S_R1:    return int'(r1);
      S_GC:    return int'(gc);
      S_CNT0:  return int'(grant_cnt0);
      S_CNT1:  return int'(grant_cnt1);
      S_MUTEX: return int'(mutex_err);
      S_PROTO: return int'(proto_err);
      S_BUSY:  return int'(busy);
      S_SAT1:  return int'(s_cnt1);
      default: return -1;
    endcase
  endfunction

  task automatic tally(input string name, input int act, input int exp_v);
    tests_run++;
    if (act != exp_v) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic checkOutput(input string name, input sel_t sel, input int value);
    exp_t e;
    e.name = name;
    e.sel = sel;
    e.value = value;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    #2;
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tally(e.name, read_sel(e.sel), e.value);
    end
  end

  task automatic applyStimulus(input logic e, input logic [1:0] m,
                               input logic [3:0] h, input logic [3:0] d);
    en = e; req_mask = m; hold_cycles = h; gc_delay = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    while ((busy || gc || r0 || r1 || rc_a) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) tally({name, "_idle_timeout"}, n, -1);
    repeat (3) @(negedge clk);
  endtask

  // Grants client 0 once and returns the number of cycles r0 stayed high after HOLD entry
  task automatic singleGrant(input string name, input int limit, output int hold_n);
    int n = 0;
    hold_n = 0;
    while (grants0 < 1 && n < limit) begin @(negedge clk); n++; end
    en = 1'b0;
    while (grant_cnt0 != 8'd1 && n < limit) begin @(negedge clk); n++; end
    if (n >= limit) tally({name, "_grant_timeout"}, n, -1);
    while (r0 && hold_n < 50) begin hold_n++; @(negedge clk); end
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int hold_n, lat, n, diff;

    // Reset state, sampled while reset is still asserted
    applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_r0", S_R0, 0);
    checkOutput("rst_r1", S_R1, 0);
    checkOutput("rst_gc", S_GC, 0);
    checkOutput("rst_cnt0", S_CNT0, 0);
    checkOutput("rst_cnt1", S_CNT1, 0);
    checkOutput("rst_mutex", S_MUTEX, 0);
    checkOutput("rst_proto", S_PROTO, 0);
    checkOutput("rst_busy", S_BUSY, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single client, hold=3: four HOLD cycles, one grant, no errors
    model_on = 1'b1;
    applyStimulus(1'b1, 2'b01, 4'd3, 4'd0);
    singleGrant("single", 200, hold_n);
    tally("single_hold_cycles", hold_n, 4);
    waitIdle("single", 200);
    checkOutput("single_cnt0", S_CNT0, 1);
    checkOutput("single_cnt1", S_CNT1, 0);
    checkOutput("single_r0_low", S_R0, 0);
    checkOutput("single_mutex", S_MUTEX, 0);
    checkOutput("single_proto", S_PROTO, 0);

    // hold=0 still gives exactly one HOLD cycle
    doReset();
    applyStimulus(1'b1, 2'b01, 4'd0, 4'd0);
    singleGrant("hold0", 200, hold_n);
    tally("hold0_hold_cycles", hold_n, 1);
    waitIdle("hold0", 200);
    checkOutput("hold0_cnt0", S_CNT0, 1);

    // Contention for 100 cycles
    doReset();
    applyStimulus(1'b1, 2'b11, 4'd2, 4'd1);
    repeat (100) @(negedge clk);
    en = 1'b0;
    waitIdle("contend", 400);
    tally("contend_cnt0_vs_model", int'(grant_cnt0), grants0);
    tally("contend_cnt1_vs_model", int'(grant_cnt1), grants1);
    tally("contend_total", int'(grant_cnt0) + int'(grant_cnt1), grants0 + grants1);
    diff = int'(grant_cnt0) - int'(grant_cnt1);
    tally("contend_alternate", (diff >= -1 && diff <= 1 && grant_cnt0 > 8'd1) ? 1 : 0, 1);
    checkOutput("contend_mutex", S_MUTEX, 0);
    checkOutput("contend_proto", S_PROTO, 0);

    // Root delay 5: gc edges arrive SYNC + 1 + (5 + 1) cycles after rc_a moves
    doReset();
    model_on = 1'b0;
    applyStimulus(1'b0, 2'b00, 4'd0, 4'd5);
    man_rc = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!gc && lat < 40);
    tally("root_rise_latency", lat, SYNC + 1 + 6);
    repeat (3) @(negedge clk);
    man_rc = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (gc && lat < 40);
    tally("root_fall_latency", lat, SYNC + 1 + 6);
    checkOutput("root_clean_proto", S_PROTO, 0);

    // rc withdrawn during R_UP: proto_err set, sequence still completes
    @(negedge clk);
    man_rc = 1'b1;
    repeat (4) @(negedge clk);
    man_rc = 1'b0;
    n = 0;
    while (!gc && n < 40) begin @(negedge clk); n++; end
    tally("root_early_gc_rises", int'(gc), 1);
    waitIdle("root_early", 60);
    checkOutput("root_early_proto", S_PROTO, 1);
    checkOutput("root_early_gc_low", S_GC, 0);

    // Fault injection: both grants high for three cycles
    doReset();
    man_g0 = 1'b1; man_g1 = 1'b1;
    repeat (3) @(negedge clk);
    man_g0 = 1'b0; man_g1 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("fault_mutex", S_MUTEX, 1);
    checkOutput("fault_proto", S_PROTO, 1);
    repeat (10) @(negedge clk);
    checkOutput("fault_mutex_sticky", S_MUTEX, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("fault_mutex_cleared", S_MUTEX, 0);
    checkOutput("fault_proto_cleared", S_PROTO, 0);

    // Reset in HOLD with two cycles left
    doReset();
    model_on = 1'b1;
    applyStimulus(1'b1, 2'b01, 4'd5, 4'd0);
    n = 0;
    while (grant_cnt0 != 8'd1 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    tally("midhold_r0_before", int'(r0), 1);
    tally("midhold_gc_before", int'(gc), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midhold_r0", S_R0, 0);
    checkOutput("midhold_r1", S_R1, 0);
    checkOutput("midhold_gc", S_GC, 0);
    checkOutput("midhold_cnt0", S_CNT0, 0);
    checkOutput("midhold_busy", S_BUSY, 0);
    applyStimulus(1'b0, 2'b00, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Saturation: five grants to client 1 on the 2-bit instance
    doReset();
    applyStimulus(1'b1, 2'b10, 4'd0, 4'd0);
    n = 0;
    while (grants1 < 5 && n < 600) begin @(negedge clk); n++; end
    en = 1'b0;
    if (n >= 600) tally("sat_grant_timeout", n, -1);
    waitIdle("sat", 200);
    checkOutput("sat_cnt1_wide", S_CNT1, 5);
    checkOutput("sat_cnt1_narrow", S_SAT1, 3);
    checkOutput("sat_cnt0_wide", S_CNT0, 0);

    repeat (2) @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arbiter_env_ctrl.md
ARBITER_ENV_CTRL -- requirements
Module: arbiter_env_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, flops per synchronizer on each asynchronous input (minimum 2).
REQ-002 Parameter CNT_W, default 8, width of each grant counter.
REQ-003 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  allows clients to start new requests.
REQ-006 req_mask  in  2  bit i enables client i.
REQ-007 hold_cycles  in  4  cycles a client holds a grant before releasing its request.
REQ-008 gc_delay  in  4  root-responder delay, in cycles, before each gc edge.
REQ-009 g0_a, g1_a, rc_a  in  1 each  asynchronous grant/request outputs of the two-input arbiter cell.
REQ-010 r0, r1  out  1 each  client requests into the arbiter cell, registered.
REQ-011 gc  out  1  parent grant into the arbiter cell, registered.
REQ-012 grant_cnt0, grant_cnt1  out  CNT_W each  completed grants per client.
REQ-013 mutex_err  out  1  sticky: both grants seen high together.
REQ-014 proto_err  out  1  sticky: grant rose without request, or rc fell while gc low mid-cycle.
REQ-015 busy  out  1  any client or root FSM is not idle.

Function
REQ-016 g0_a, g1_a and rc_a SHALL each pass through a SYNC_STAGES-deep synchronizer; all logic uses only the synchronized versions g0_s, g1_s and rc_s.
REQ-017 Each client FSM SHALL have states IDLE(r=0), REQ(r=1), HOLD(r=1), REL(r=0).
REQ-018 IDLE->REQ when en=1, req_mask[i]=1 and g_s=0; REQ->HOLD when g_s=1, loading the hold counter with hold_cycles.
REQ-019 HOLD decrements each cycle; HOLD->REL in the cycle the counter reads 0, so hold_cycles=0 gives one HOLD cycle.
REQ-020 REL->IDLE when g_s=0; a client SHALL NOT re-request until back in IDLE (4-phase).
REQ-021 grant_cnt_i SHALL increment on each REQ->HOLD transition and saturate at all-ones.
REQ-022 Deasserting en or req_mask[i] mid-handshake SHALL NOT abort it; the client completes to IDLE and then stays there.
REQ-023 Root FSM states: R_IDLE(gc=0), R_UP(gc=0), R_GNT(gc=1), R_DN(gc=1).
REQ-024 R_IDLE->R_UP on rc_s=1, loading gc_delay; R_UP->R_GNT when the counter reads 0, so gc rises gc_delay+1 cycles after rc_s is seen high.
REQ-025 R_GNT->R_DN on rc_s=0, loading gc_delay; R_DN->R_IDLE when the counter reads 0, so gc falls gc_delay+1 cycles after rc_s is seen low.
REQ-026 If rc_s falls while in R_UP, proto_err SHALL be set; the FSM completes the R_UP->R_GNT->R_DN->R_IDLE sequence unchanged.
REQ-027 mutex_err SHALL set in any cycle with g0_s=g1_s=1; proto_err SHALL set when g_s rises while the client is in IDLE.
REQ-028 Both clients may enter REQ in the same cycle; no local priority is applied.
REQ-029 gc_delay and hold_cycles are sampled only at counter load.

Reset
REQ-030 While wb_rst_i=1: r0=r1=gc=0, all FSMs idle, counters, synchronizers, mutex_err and proto_err cleared, busy=0.
REQ-031 Reset mid-handshake SHALL drop r0, r1 and gc on the next edge regardless of arbiter state.

Structure
REQ-032 A shared package SHALL hold the client and root state encodings and SYNC_STAGES/CNT_W defaults.
REQ-033 The client FSM, with its counter, SHALL be sub-module hs4_client, instanced twice.

Verification
REQ-034 Single client: req_mask=01, hold=3, gc_delay=0, arbiter model -> r0 high, g0, exactly 4 HOLD cycles, r0 low, grant_cnt0=1, no errors.
REQ-035 Contention: req_mask=11, en=1 for 100 cycles -> grants alternate, mutex_err=0, grant_cnt0+grant_cnt1 equals completed handshakes.
REQ-036 Root delay: rc_a pulsed with gc_delay=5 -> gc rises 6 cycles after rc_s, falls 6 cycles after rc_s low.
REQ-037 Fault inject: force g0_a=g1_a=1 for 3 cycles -> mutex_err=1 and held until reset.
REQ-038 Reset at HOLD with 2 cycles left -> r0=r1=gc=0 next edge, grant_cnt=0, busy=0.
REQ-039 Saturation: CNT_W=2, 5 grants to client 1 -> grant_cnt1=3.
